// File: rtl/map_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : map_arbiter
//  Brief    : Shares one combinational map ROM between the pixel-timed map
//             overlay (priority, one-entry cell cache) and the stallable wall
//             tracer (request/ack, with a starvation limit).
//  Revision : 1.0 - initial release
// ============================================================================
module map_arbiter #(
    parameter int MAP_WIDTH_BITS  = 4,
    parameter int MAP_HEIGHT_BITS = 4,
    parameter int MAX_WAIT        = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ov_req,
    input  logic [MAP_WIDTH_BITS-1:0]  ov_col,
    input  logic [MAP_HEIGHT_BITS-1:0] ov_row,
    output logic                       ov_val,
    output logic                       ov_valid,
    input  logic                       tr_req,
    input  logic [MAP_WIDTH_BITS-1:0]  tr_col,
    input  logic [MAP_HEIGHT_BITS-1:0] tr_row,
    output logic                       tr_ack,
    output logic                       tr_val,
    output logic [MAP_WIDTH_BITS-1:0]  o_map_col,
    output logic [MAP_HEIGHT_BITS-1:0] o_map_row,
    input  logic                       i_map_val
);

    localparam int         c_TAG_W    = MAP_WIDTH_BITS + MAP_HEIGHT_BITS;
    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    logic [c_TAG_W-1:0] r_tag;
    logic               r_tag_valid;
    logic [3:0]         r_wait_cnt;
    logic               r_ov_val;
    logic               r_ov_valid;
    logic               r_tr_ack;
    logic               r_tr_val;

    logic [c_TAG_W-1:0] w_ov_addr;
    logic               w_hit;
    logic               w_ov_need;
    logic               w_force_tr;
    logic               w_gnt_ov;
    logic               w_gnt_tr;

    assign w_ov_addr = {ov_col, ov_row};

    // Cache lookup, starvation override and grant decision for this cycle.
    // The tracer is blocked during its ack cycle because it still presents
    // the request it has just been answered for.
    always_comb begin
        w_hit      = ov_req && r_tag_valid && (w_ov_addr == r_tag);
        w_ov_need  = ov_req && !w_hit;
        w_force_tr = tr_req && !r_tr_ack && (r_wait_cnt == c_MAX_WAIT);
        w_gnt_ov   = !reset && w_ov_need && !w_force_tr;
        w_gnt_tr   = !reset && tr_req && !r_tr_ack && !w_gnt_ov;
    end

    // ROM address: overlay only when it owns the cycle, tracer otherwise
    // (idle cycles included, so the tracer address is already settled).
    always_comb begin
        o_map_col = tr_col;
        o_map_row = tr_row;
        if (w_gnt_ov) begin
            o_map_col = ov_col;
            o_map_row = ov_row;
        end
    end

    // Overlay side: cache fill on a granted miss; a hit leaves ov_val as is
    // since it already holds the cached cell. A pre-empted miss reports
    // not-valid and the overlay draws the stale value for that pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ov_val    <= 1'b0;
            r_ov_valid  <= 1'b0;
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
        end else begin
            r_ov_valid <= ov_req && (w_hit || w_gnt_ov);
            if (w_gnt_ov) begin
                r_ov_val    <= i_map_val;
                r_tag       <= w_ov_addr;
                r_tag_valid <= 1'b1;
            end
        end
    end

    // Tracer side: one-cycle ack carrying the read value, plus the count of
    // consecutive cycles a pending request has lost to the overlay.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tr_ack   <= 1'b0;
            r_tr_val   <= 1'b0;
            r_wait_cnt <= 4'd0;
        end else begin
            r_tr_ack <= w_gnt_tr;
            if (w_gnt_tr) begin
                r_tr_val <= i_map_val;
            end
            if (w_gnt_tr || !tr_req) begin
                r_wait_cnt <= 4'd0;
            end else if (!r_tr_ack && (r_wait_cnt != c_MAX_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

    assign ov_val   = r_ov_val;
    assign ov_valid = r_ov_valid;
    assign tr_ack   = r_tr_ack;
    assign tr_val   = r_tr_val;

endmodule
`default_nettype wire

// File: tb/tb_map_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_map_arbiter
//  Brief    : Directed-vector bench for map_arbiter with a queue scoreboard.
//             Each vector drives one cycle and queues the hand-computed
//             outputs expected mid-cycle; a monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_map_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ov_req = 1'b0;
    logic [3:0] ov_col = 4'd0;
    logic [3:0] ov_row = 4'd0;
    logic       ov_val;
    logic       ov_valid;
    logic       tr_req = 1'b0;
    logic [3:0] tr_col = 4'd0;
    logic [3:0] tr_row = 4'd0;
    logic       tr_ack;
    logic       tr_val;
    logic [3:0] o_map_col;
    logic [3:0] o_map_row;
    logic       i_map_val;

    logic       rom [0:255];

    typedef struct {
        int   row;
        logic chk;
        logic ov_valid;
        logic ov_val;
        logic tr_ack;
        logic tr_val;
        logic [7:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   row_no   = 0;

    always #5 clk = ~clk;

    // Map ROM: combinational read, a handful of cells set to 1.
    assign i_map_val = rom[{o_map_col, o_map_row}];

    map_arbiter #(
        .MAP_WIDTH_BITS (4),
        .MAP_HEIGHT_BITS(4),
        .MAX_WAIT       (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ov_req   (ov_req),
        .ov_col   (ov_col),
        .ov_row   (ov_row),
        .ov_val   (ov_val),
        .ov_valid (ov_valid),
        .tr_req   (tr_req),
        .tr_col   (tr_col),
        .tr_row   (tr_row),
        .tr_ack   (tr_ack),
        .tr_val   (tr_val),
        .o_map_col(o_map_col),
        .o_map_row(o_map_row),
        .i_map_val(i_map_val)
    );

    task automatic check(input string name, input int row, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, req);
        end
    endtask

    // Monitor: mid-cycle, compare registered outputs and the ROM address.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk) begin
                check("ov_valid", e.row, int'(ov_valid), int'(e.ov_valid));
                check("ov_val",   e.row, int'(ov_val),   int'(e.ov_val));
                check("tr_ack",   e.row, int'(tr_ack),   int'(e.tr_ack));
                check("tr_val",   e.row, int'(tr_val),   int'(e.tr_val));
            end
            check("map_addr", e.row, int'({o_map_col, o_map_row}), int'(e.addr));
        end
    end

    // One cycle of stimulus; expected values are those visible during it
    // (registered outputs from the previous edge, ROM address of this cycle).
    task automatic vec(input logic rst, input logic ovr, input int oc, input int orw,
                       input logic trr, input int tc, input int trw,
                       input int ec, input int er, input logic chk,
                       input logic e_ovv, input logic e_ov, input logic e_ack, input logic e_trv);
        exp_t e;
        @(posedge clk);
        #1;
        reset  = rst;
        ov_req = ovr;
        ov_col = 4'(oc);
        ov_row = 4'(orw);
        tr_req = trr;
        tr_col = 4'(tc);
        tr_row = 4'(trw);
        e.row = row_no;
        e.chk = chk;
        e.ov_valid = e_ovv;
        e.ov_val = e_ov;
        e.tr_ack = e_ack;
        e.tr_val = e_trv;
        e.addr = {4'(ec), 4'(er)};
        exp_q.push_back(e);
        row_no++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 1'b0;
        rom[8'h35] = 1'b1;
        rom[8'h99] = 1'b1;
        rom[8'h01] = 1'b1;
        rom[8'h03] = 1'b1;
        rom[8'h11] = 1'b1;

        //  rst ovr oc orw  trr tc trw   addr  chk ovv ov ack trv
        // reset then idle
        vec(1, 0, 0, 0,  0, 1, 2,  1, 2,  0, 0, 0, 0, 0);
        vec(1, 0, 0, 0,  0, 1, 2,  1, 2,  1, 0, 0, 0, 0);
        vec(0, 0, 0, 0,  0, 6, 4,  6, 4,  1, 0, 0, 0, 0);
        // single tracer read at (3,5); no re-grant during ack cycle
        vec(0, 0, 0, 0,  1, 3, 5,  3, 5,  1, 0, 0, 0, 0);
        vec(0, 0, 0, 0,  1, 3, 5,  3, 5,  1, 0, 0, 1, 1);
        vec(0, 0, 0, 0,  1, 3, 5,  3, 5,  1, 0, 0, 0, 1);
        vec(0, 0, 0, 0,  0, 3, 5,  3, 5,  1, 0, 0, 1, 1);
        vec(0, 0, 0, 0,  0, 3, 5,  3, 5,  1, 0, 0, 0, 1);
        // overlay repeats (2,7): one miss, then hits free the ROM for tracer
        vec(0, 1, 2, 7,  0, 4, 4,  2, 7,  1, 0, 0, 0, 1);
        vec(0, 1, 2, 7,  0, 4, 4,  4, 4,  1, 1, 0, 0, 1);
        vec(0, 1, 2, 7,  1, 5, 5,  5, 5,  1, 1, 0, 0, 1);
        vec(0, 1, 2, 7,  1, 5, 5,  5, 5,  1, 1, 0, 1, 0);
        vec(0, 0, 2, 7,  0, 4, 4,  4, 4,  1, 1, 0, 0, 0);
        vec(0, 0, 2, 7,  0, 4, 4,  4, 4,  1, 0, 0, 0, 0);
        // overlay misses every cycle; tracer forced after 3 lost cycles
        vec(0, 1, 0, 1,  1, 9, 9,  0, 1,  1, 0, 0, 0, 0);
        vec(0, 1, 0, 2,  1, 9, 9,  0, 2,  1, 1, 1, 0, 0);
        vec(0, 1, 0, 3,  1, 9, 9,  0, 3,  1, 1, 0, 0, 0);
        vec(0, 1, 0, 4,  1, 9, 9,  9, 9,  1, 1, 1, 0, 0);
        vec(0, 1, 0, 5,  1, 9, 9,  0, 5,  1, 0, 1, 1, 1);
        vec(0, 1, 0, 6,  0, 9, 9,  0, 6,  1, 1, 0, 0, 1);
        vec(0, 0, 0, 6,  0, 9, 9,  9, 9,  1, 1, 0, 0, 1);
        // concurrent miss and tracer request with wait_cnt = 0
        vec(0, 1, 1, 1,  1, 6, 4,  1, 1,  1, 0, 0, 0, 1);
        vec(0, 1, 1, 1,  1, 6, 4,  6, 4,  1, 1, 1, 0, 1);
        vec(0, 1, 1, 1,  1, 6, 4,  6, 4,  1, 1, 1, 1, 0);
        // reset on a would-be tracer grant: ack dropped, cache invalidated
        vec(1, 0, 1, 1,  1, 3, 5,  3, 5,  1, 1, 1, 0, 0);
        vec(0, 1, 1, 1,  0, 3, 5,  1, 1,  1, 0, 0, 0, 0);
        vec(0, 1, 1, 1,  0, 3, 5,  3, 5,  1, 1, 1, 0, 0);
        vec(0, 0, 1, 1,  0, 3, 5,  3, 5,  1, 1, 1, 0, 0);
        vec(0, 0, 1, 1,  0, 3, 5,  3, 5,  1, 0, 1, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
